wb_mp_ram: RTL and testbench

WB_MP_RAM -- requirements
Module: wb_mp_ram

---
 rtl/wb_mp_ram_if.sv | 30 +++
 rtl/wb_mp_ram.sv | 121 ++++++++++++
 tb/tb_wb_mp_ram.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_mp_ram_if.sv
// Multi-port Wishbone bundle: per-port slices packed into flat buses.
// Port k occupies [k*W +: W] of every p_* vector.
interface wb_mp_ram_if #(
  parameter int NUM_PORTS    = 2,
  parameter int DATA_WIDTH   = 32,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int ADDR_WIDTH   = 12
);
  logic [NUM_PORTS*ADDR_WIDTH-1:0]   p_adr_i;
  logic [NUM_PORTS*DATA_WIDTH-1:0]   p_dat_i;
  logic [NUM_PORTS*DATA_WIDTH-1:0]   p_dat_o;
  logic [NUM_PORTS-1:0]              p_we_i;
  logic [NUM_PORTS*SELECT_WIDTH-1:0] p_sel_i;
  logic [NUM_PORTS-1:0]              p_stb_i;
  logic [NUM_PORTS-1:0]              p_cyc_i;
  logic [NUM_PORTS-1:0]              p_ack_o;
  logic [NUM_PORTS-1:0]              p_err_o;

  modport master (
    output p_adr_i, p_dat_i, p_we_i,
    output p_sel_i, p_stb_i, p_cyc_i,
    input  p_dat_o, p_ack_o, p_err_o
  );

  modport slave (
    input  p_adr_i, p_dat_i, p_we_i,
    input  p_sel_i, p_stb_i, p_cyc_i,
    output p_dat_o, p_ack_o, p_err_o
  );
endinterface

// File: rtl/wb_mp_ram.sv
// Multi-port Wishbone RAM: round-robin arbitration, one access per cycle.
// Ports: clk, rst_n (async active-low), bus (wb_mp_ram_if.slave).
module wb_mp_ram #(
  parameter int NUM_PORTS    = 2,
  parameter int DATA_WIDTH   = 32,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int MEM_WORDS    = 1024,
  parameter int ADDR_WIDTH   =
    $clog2(MEM_WORDS * SELECT_WIDTH),
  parameter int LOAD_IMAGE   = 0,
  parameter     INIT_FILE    = "@IMAGE@"
) (
  input  logic       clk,
  input  logic       rst_n,
  wb_mp_ram_if.slave bus
);

  localparam int OFFW = $clog2(SELECT_WIDTH);
  localparam int IDXW =
    (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int PW =
    (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int DW = DATA_WIDTH;
  localparam int SW = SELECT_WIDTH;
  localparam int AW = ADDR_WIDTH;

  logic [DW-1:0] mem_q [MEM_WORDS];

  logic [NUM_PORTS-1:0]    ack_q, ack_d;
  logic [NUM_PORTS-1:0]    err_q, err_d;
  logic [NUM_PORTS*DW-1:0] dat_q, dat_d;
  logic [PW-1:0]           last_q, last_d;

  logic [NUM_PORTS-1:0] req;
  logic                 gnt_vld;
  logic [PW-1:0]        gnt;
  logic [AW-1:0]        g_adr;
  logic [AW-1:0]        g_widx;
  logic                 g_inr;

  logic          wr_en;
  logic [IDXW-1:0] wr_idx;
  logic [DW-1:0] wr_dat;
  logic [SW-1:0] wr_sel;

  // A port that is being answered this cycle is masked so a held
  // strobe is not counted as a second request.
  assign req = bus.p_cyc_i & bus.p_stb_i
             & ~ack_q & ~err_q;

  always_comb begin : p_arb
    int idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt     = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = (int'(last_q) + 1 + i) % NUM_PORTS;
      if (!gnt_vld && req[idx]) begin
        gnt_vld = 1'b1;
        gnt     = PW'(idx);
      end
    end
  end

  always_comb begin
    g_adr  = bus.p_adr_i[int'(gnt)*AW +: AW];
    g_widx = g_adr >> OFFW;
    g_inr  = int'(g_widx) < MEM_WORDS;
    wr_idx = g_widx[IDXW-1:0];
    wr_dat = bus.p_dat_i[int'(gnt)*DW +: DW];
    wr_sel = bus.p_sel_i[int'(gnt)*SW +: SW];
  end

  always_comb begin
    ack_d  = '0;
    err_d  = '0;
    dat_d  = dat_q;
    last_d = last_q;
    wr_en  = 1'b0;
    if (gnt_vld) begin
      last_d = gnt;
      if (g_inr) begin
        ack_d[gnt] = 1'b1;
        dat_d[int'(gnt)*DW +: DW] = mem_q[wr_idx];
        wr_en = bus.p_we_i[gnt];
      end else begin
        err_d[gnt] = 1'b1;
      end
    end
  end

  // Storage has no reset: contents survive rst_n.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < SW; b++) begin
        if (wr_sel[b])
          mem_q[wr_idx][b*8 +: 8] <= wr_dat[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q  <= '0;
      err_q  <= '0;
      dat_q  <= '0;
      // Last grant = top port, so port 0 wins first.
      last_q <= PW'(NUM_PORTS - 1);
    end else begin
      ack_q  <= ack_d;
      err_q  <= err_d;
      dat_q  <= dat_d;
      last_q <= last_d;
    end
  end

  assign bus.p_ack_o = ack_q;
  assign bus.p_err_o = err_q;
  assign bus.p_dat_o = dat_q;

endmodule

// File: tb/tb_wb_mp_ram.sv
// Self-checking bench for wb_mp_ram (3 ports, 1000 words).
// Table of single-port vectors plus arbitration/reset sequences.
module tb_wb_mp_ram;

  localparam int NP = 3;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int MW = 1000;
  localparam int AW = 12;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  wb_mp_ram_if #(
    .NUM_PORTS(NP), .DATA_WIDTH(DW),
    .SELECT_WIDTH(SW), .ADDR_WIDTH(AW)
  ) bus ();

  wb_mp_ram #(
    .NUM_PORTS(NP), .DATA_WIDTH(DW),
    .SELECT_WIDTH(SW), .MEM_WORDS(MW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          port;
    logic        we;
    logic [11:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        exp_err;
    logic        chk;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t tbl [15];

  task automatic check(input string name,
                       input logic [127:0] act,
                       input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic set_port(input int p, input logic cyc,
                          input logic we,
                          input logic [11:0] adr,
                          input logic [31:0] dat,
                          input logic [3:0] sel);
    bus.p_cyc_i[p]           = cyc;
    bus.p_stb_i[p]           = cyc;
    bus.p_we_i[p]            = we;
    bus.p_adr_i[p*AW +: AW]  = adr;
    bus.p_dat_i[p*DW +: DW]  = dat;
    bus.p_sel_i[p*SW +: SW]  = sel;
  endtask

  task automatic do_vec(input int n, input vec_t v);
    int lat;
    logic [1:0] resp;
    logic [31:0] d;
    lat  = 0;
    resp = 2'b00;
    d    = '0;
    set_port(v.port, 1'b1, v.we, v.adr, v.dat, v.sel);
    while (lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
      resp = {bus.p_ack_o[v.port], bus.p_err_o[v.port]};
      d    = bus.p_dat_o[v.port*DW +: DW];
      if (resp != 2'b00) break;
    end
    set_port(v.port, 1'b0, 1'b0, '0, '0, '0);
    check($sformatf("v%0d_resp", n), 128'(resp),
          v.exp_err ? 128'(2'b01) : 128'(2'b10));
    check($sformatf("v%0d_lat", n), 128'(lat), 128'(1));
    if (v.chk)
      check($sformatf("v%0d_dat", n), 128'(d),
            128'(v.exp_dat));
    @(posedge clk);
    #1;
    check($sformatf("v%0d_pulse", n),
          128'({bus.p_ack_o[v.port], bus.p_err_o[v.port]}),
          128'(0));
  endtask

  initial begin : main
    int c0;
    int c1;
    logic [31:0] d1;
    n_chk  = 0;
    n_fail = 0;
    bus.p_cyc_i = '0;
    bus.p_stb_i = '0;
    bus.p_we_i  = '0;
    bus.p_adr_i = '0;
    bus.p_dat_i = '0;
    bus.p_sel_i = '0;

    tbl[0]  = '{0, 1, 12'h010, 32'hDEADBEEF, 4'hF, 0, 0, 0};
    tbl[1]  = '{0, 0, 12'h010, 32'h0, 4'hF, 0, 1, 32'hDEADBEEF};
    tbl[2]  = '{1, 1, 12'h010, 32'h00AA0000, 4'h4, 0, 1, 32'hDEADBEEF};
    tbl[3]  = '{1, 0, 12'h012, 32'h0, 4'h0, 0, 1, 32'hDEAABEEF};
    tbl[4]  = '{2, 1, 12'h020, 32'hA5A5A5A5, 4'hF, 0, 0, 0};
    tbl[5]  = '{2, 1, 12'h020, 32'h12345678, 4'h9, 0, 1, 32'hA5A5A5A5};
    tbl[6]  = '{0, 0, 12'h020, 32'h0, 4'hF, 0, 1, 32'h12A5A578};
    tbl[7]  = '{1, 1, 12'hF9C, 32'hCAFEF00D, 4'hF, 0, 0, 0};
    tbl[8]  = '{2, 0, 12'hF9C, 32'h0, 4'hF, 0, 1, 32'hCAFEF00D};
    tbl[9]  = '{0, 0, 12'hFA0, 32'h0, 4'hF, 1, 1, 32'h12A5A578};
    tbl[10] = '{1, 1, 12'h020, 32'h0, 4'hF, 0, 1, 32'h12A5A578};
    tbl[11] = '{1, 0, 12'h020, 32'h0, 4'hF, 0, 1, 32'h00000000};
    tbl[12] = '{0, 0, 12'hFFC, 32'h0, 4'hF, 1, 1, 32'h12A5A578};
    tbl[13] = '{2, 1, 12'hFA0, 32'hFFFFFFFF, 4'hF, 1, 1, 32'hCAFEF00D};
    tbl[14] = '{2, 0, 12'hF9C, 32'h0, 4'hF, 0, 1, 32'hCAFEF00D};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 128'(bus.p_ack_o), 128'(0));
    check("rst_err", 128'(bus.p_err_o), 128'(0));
    check("rst_dat", 128'(bus.p_dat_o), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Same-cycle write (port 0) and read (port 1).
    set_port(0, 1'b1, 1'b1, 12'h030, 32'h1, 4'hF);
    set_port(1, 1'b1, 1'b0, 12'h030, 32'h0, 4'hF);
    c0 = 0;
    c1 = 0;
    d1 = '0;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk);
      #1;
      if (bus.p_ack_o[0] && c0 == 0) begin
        c0 = c;
        set_port(0, 1'b0, 1'b0, '0, '0, '0);
      end
      if (bus.p_ack_o[1] && c1 == 0) begin
        c1 = c;
        d1 = bus.p_dat_o[DW +: DW];
        set_port(1, 1'b0, 1'b0, '0, '0, '0);
      end
    end
    check("race_p0_cycle", 128'(c0), 128'(1));
    check("race_p1_cycle", 128'(c1), 128'(2));
    check("race_p1_dat", 128'(d1), 128'(32'h1));

    for (int i = 0; i < 15; i++) do_vec(i, tbl[i]);

    // All three ports requesting from reset.
    @(negedge clk);
    rst_n = 1'b0;
    for (int p = 0; p < NP; p++)
      set_port(p, 1'b1, 1'b0, 12'h010, 32'h0, 4'hF);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("rr_ack%0d", i),
            128'(bus.p_ack_o), 128'(3'b001 << (i % 3)));
      if (i == 0)
        check("rr_p0_dat", 128'(bus.p_dat_o[0 +: DW]),
              128'(32'hDEAABEEF));
    end
    for (int p = 0; p < NP; p++)
      set_port(p, 1'b0, 1'b0, '0, '0, '0);
    @(posedge clk);
    #1;
    check("rr_idle", 128'(bus.p_ack_o), 128'(0));

    // Reset while port 1 holds an ack.
    set_port(1, 1'b1, 1'b0, 12'h010, 32'h0, 4'hF);
    @(posedge clk);
    #1;
    check("mid_ack_seen", 128'(bus.p_ack_o), 128'(3'b010));
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ack", 128'(bus.p_ack_o), 128'(0));
    check("mid_rst_err", 128'(bus.p_err_o), 128'(0));
    check("mid_rst_dat", 128'(bus.p_dat_o), 128'(0));
    set_port(1, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_vec(15, '{1, 0, 12'h010, 32'h0, 4'hF, 0, 1,
                 32'hDEAABEEF});
    do_vec(16, '{0, 0, 12'h030, 32'h0, 4'hF, 0, 1,
                 32'h00000001});

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
